// File: rtl/lzd_pkg.sv
// lzd_pkg: shared constants, types and helpers for the pipelined
// leading-zero detector / normaliser (lzd_pipe) and its group detector.
//   GROUP_W    : bits examined by one group detector
//   LZG_W      : width of the in-group leading-zero count
//   grp_info_t : per-group result held in the stage-1 payload
//   lzd_cnt_w  : width of the leading-zero count for a given operand width
package lzd_pkg;

    localparam int GROUP_W = 8;
    localparam int LZG_W   = 3;

    // Per-group detector result: all-zero flag plus in-group count.
    typedef struct packed {
        logic             zero;
        logic [LZG_W-1:0] lz;
    } grp_info_t;

    // The count must be able to represent XLEN itself (all-zero operand).
    function automatic int lzd_cnt_w(input int xlen);
        return $clog2(xlen + 1);
    endfunction

endpackage

// File: rtl/lzd_group8.sv
// lzd_group8: combinational leading-zero detector for one 8-bit group.
// Ports:
//   data_i  in  8  group bits, bit 7 is the most significant
//   zero_o  out 1  all eight bits are zero
//   lz_o    out 3  leading zeros inside the group (0 when zero_o is set)
module lzd_group8
    import lzd_pkg::*;
(
    input  logic [GROUP_W-1:0] data_i,
    output logic               zero_o,
    output logic [LZG_W-1:0]   lz_o
);

    logic [LZG_W-1:0] lz_s;

    // Priority encode the first set bit from the MSB end.
    always_comb begin
        lz_s = 3'd0;
        casez (data_i)
            8'b1???????: lz_s = 3'd0;
            8'b01??????: lz_s = 3'd1;
            8'b001?????: lz_s = 3'd2;
            8'b0001????: lz_s = 3'd3;
            8'b00001???: lz_s = 3'd4;
            8'b000001??: lz_s = 3'd5;
            8'b0000001?: lz_s = 3'd6;
            8'b00000001: lz_s = 3'd7;
            default:     lz_s = 3'd0;
        endcase
    end

    assign zero_o = (data_i == 8'h00);
    assign lz_o   = lz_s;

endmodule

// File: rtl/lzd_pipe.sv
// lzd_pipe: two-stage pipelined leading-zero counter and normaliser.
// Stage 1 registers per-group detector results with the operand and tag;
// stage 2 picks the first non-zero group, forms the count and shifts.
// Ports:
//   clk_i    in   1      clock, rising edge
//   rst_i    in   1      synchronous active-high reset
//   valid_i  in   1      operand valid
//   ready_o  out  1      operand accepted this cycle when valid_i is set
//   data_i   in   XLEN   operand
//   tag_i    in   TAG_W  sideband tag
//   valid_o  out  1      result valid
//   ready_i  in   1      downstream takes the result
//   count_o  out  CNT_W  leading zeros (XLEN for a zero operand)
//   zero_o   out  1      operand was zero
//   norm_o   out  XLEN   operand shifted left by count_o (0 when zero)
//   tag_o    out  TAG_W  tag of the presented result
module lzd_pipe
    import lzd_pkg::*;
#(
    parameter  int XLEN  = 64,
    parameter  int TAG_W = 4,
    localparam int CNT_W = lzd_cnt_w(XLEN)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [XLEN-1:0]  data_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [CNT_W-1:0] count_o,
    output logic             zero_o,
    output logic [XLEN-1:0]  norm_o,
    output logic [TAG_W-1:0] tag_o
);

    localparam int G = XLEN / GROUP_W;

    if (((XLEN % GROUP_W) != 0) || (XLEN < 16)) begin : g_bad_xlen
        $error("lzd_pipe: XLEN must be a multiple of 8 and at least 16");
    end

    // Index 0 of grp is the most significant group.
    typedef struct packed {
        grp_info_t [G-1:0] grp;
        logic [XLEN-1:0]   data;
        logic [TAG_W-1:0]  tag;
    } s1_t;

    logic             grp_zero_s [G];
    logic [LZG_W-1:0] grp_lz_s   [G];

    s1_t              s1_new_s;
    s1_t              s1_q, s1_d;
    logic             s1_valid_q, s1_valid_d;
    logic             s2_valid_q, s2_valid_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             zero_q, zero_d;
    logic [XLEN-1:0]  norm_q, norm_d;
    logic [TAG_W-1:0] tag_q, tag_d;

    logic             in_xfer_s, out_xfer_s, adv2_s;
    logic             any_s;
    logic [CNT_W-1:0] base_s, cnt_s;
    logic [LZG_W-1:0] lzg_s;
    logic [XLEN-1:0]  norm_s;

    for (genvar g = 0; g < G; g++) begin : g_grp
        lzd_group8 u_grp (
            .data_i (data_i[XLEN-1-GROUP_W*g -: GROUP_W]),
            .zero_o (grp_zero_s[g]),
            .lz_o   (grp_lz_s[g])
        );
    end

    assign adv2_s     = s1_valid_q & (~s2_valid_q | ready_i);
    assign ready_o    = ~s1_valid_q | adv2_s;
    assign in_xfer_s  = valid_i & ready_o;
    assign out_xfer_s = s2_valid_q & ready_i;

    // Pack the group detector results with operand and tag for stage 1.
    always_comb begin
        s1_new_s      = '0;
        for (int g = 0; g < G; g++) begin
            s1_new_s.grp[g].zero = grp_zero_s[g];
            s1_new_s.grp[g].lz   = grp_lz_s[g];
        end
        s1_new_s.data = data_i;
        s1_new_s.tag  = tag_i;
    end

    // Scan from the LSB group upward so the lowest-index (most significant)
    // non-zero group is the last one written and therefore wins.
    always_comb begin
        any_s  = 1'b0;
        base_s = '0;
        lzg_s  = '0;
        for (int k = G - 1; k >= 0; k--) begin
            any_s  = any_s | ~s1_q.grp[k].zero;
            base_s = s1_q.grp[k].zero ? base_s : CNT_W'(k * GROUP_W);
            lzg_s  = s1_q.grp[k].zero ? lzg_s  : s1_q.grp[k].lz;
        end
        cnt_s  = any_s ? (base_s + CNT_W'(lzg_s)) : CNT_W'(XLEN);
        norm_s = any_s ? (s1_q.data << cnt_s) : '0;
    end

    // Next-state for both pipeline stages; S2 only changes when S1 advances
    // or the held result is taken.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_d       = s1_q;
        s2_valid_d = s2_valid_q;
        count_d    = count_q;
        zero_d     = zero_q;
        norm_d     = norm_q;
        tag_d      = tag_q;

        if (in_xfer_s) begin
            s1_valid_d = 1'b1;
            s1_d       = s1_new_s;
        end else if (adv2_s) begin
            s1_valid_d = 1'b0;
        end else begin
            s1_valid_d = s1_valid_q;
        end

        if (adv2_s) begin
            s2_valid_d = 1'b1;
            count_d    = cnt_s;
            zero_d     = ~any_s;
            norm_d     = norm_s;
            tag_d      = s1_q.tag;
        end else if (out_xfer_s) begin
            s2_valid_d = 1'b0;
        end else begin
            s2_valid_d = s2_valid_q;
        end
    end

    // Pipeline registers; reset discards every in-flight operand.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid_q <= 1'b0;
            s1_q       <= '0;
            s2_valid_q <= 1'b0;
            count_q    <= '0;
            zero_q     <= 1'b0;
            norm_q     <= '0;
            tag_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_q       <= s1_d;
            s2_valid_q <= s2_valid_d;
            count_q    <= count_d;
            zero_q     <= zero_d;
            norm_q     <= norm_d;
            tag_q      <= tag_d;
        end
    end

    assign valid_o = s2_valid_q;
    assign count_o = count_q;
    assign zero_o  = zero_q;
    assign norm_o  = norm_q;
    assign tag_o   = tag_q;

endmodule

// File: tb/tb_lzd_pipe.sv
// Scoreboard bench for lzd_pipe at XLEN=64 (with back-pressure) and XLEN=16.
module tb_lzd_pipe;

    typedef struct {
        logic [6:0]  cnt;
        logic        zero;
        logic [63:0] norm;
        logic [3:0]  tag;
    } exp_t;

    typedef struct {
        logic [4:0]  cnt;
        logic        zero;
        logic [15:0] norm;
    } exp16_t;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [63:0] data_i = 64'h0;
    logic [3:0]  tag_i = 4'h0;
    logic        valid_o;
    logic        ready_i = 1'b1;
    logic [6:0]  count_o;
    logic        zero_o;
    logic [63:0] norm_o;
    logic [3:0]  tag_o;

    logic        v16 = 1'b0;
    logic        r16_o;
    logic [15:0] d16 = 16'h0;
    logic        vo16;
    logic        ri16 = 1'b1;
    logic [4:0]  c16;
    logic        z16;
    logic [15:0] n16;
    logic [3:0]  t16;

    int   errors = 0;
    int   checks = 0;
    int   n_acc  = 0;
    logic rdy_rand  = 1'b0;
    logic rdy_fixed = 1'b1;

    exp_t   sb[$];
    exp16_t sb16[$];

    logic        held = 1'b0;
    logic [6:0]  h_cnt;
    logic        h_zero;
    logic [63:0] h_norm;
    logic [3:0]  h_tag;

    always #5 clk = ~clk;

    lzd_pipe #(.XLEN(64), .TAG_W(4)) u_dut (
        .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
        .data_i(data_i), .tag_i(tag_i), .valid_o(valid_o), .ready_i(ready_i),
        .count_o(count_o), .zero_o(zero_o), .norm_o(norm_o), .tag_o(tag_o)
    );

    lzd_pipe #(.XLEN(16), .TAG_W(4)) u_dut16 (
        .clk_i(clk), .rst_i(rst_i), .valid_i(v16), .ready_o(r16_o),
        .data_i(d16), .tag_i(4'h0), .valid_o(vo16), .ready_i(ri16),
        .count_o(c16), .zero_o(z16), .norm_o(n16), .tag_o(t16)
    );

    // Downstream ready, changed just after each rising edge.
    always @(posedge clk) begin
        #1;
        ready_i = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_fixed;
    end

    // Monitor: pop/compare on each output transfer, check stability while stalled.
    always @(negedge clk) begin
        exp_t e;
        if (rst_i) begin
            held = 1'b0;
        end else begin
            if (held) begin
                checks++;
                if (!(valid_o && count_o == h_cnt && zero_o == h_zero && norm_o == h_norm && tag_o == h_tag)) begin
                    errors++;
                    $display("FAIL stable: got v=%0b cnt=%0d z=%0b norm=%h tag=%h, required v=1 cnt=%0d z=%0b norm=%h tag=%h",
                             valid_o, count_o, zero_o, norm_o, tag_o, h_cnt, h_zero, h_norm, h_tag);
                end
            end
            if (valid_o && ready_i) begin
                held = 1'b0;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL extra_result: got cnt=%0d tag=%h, required no result", count_o, tag_o);
                end else begin
                    e = sb.pop_front();
                    if (count_o != e.cnt || zero_o != e.zero || norm_o != e.norm || tag_o != e.tag) begin
                        errors++;
                        $display("FAIL result: got cnt=%0d z=%0b norm=%h tag=%h, required cnt=%0d z=%0b norm=%h tag=%h",
                                 count_o, zero_o, norm_o, tag_o, e.cnt, e.zero, e.norm, e.tag);
                    end
                end
            end else if (valid_o) begin
                held   = 1'b1;
                h_cnt  = count_o;
                h_zero = zero_o;
                h_norm = norm_o;
                h_tag  = tag_o;
            end else begin
                held = 1'b0;
            end
        end
    end

    // Monitor for the 16-bit instance (downstream always ready).
    always @(negedge clk) begin
        exp16_t e;
        if (!rst_i && vo16) begin
            checks++;
            if (sb16.size() == 0) begin
                errors++;
                $display("FAIL extra_result16: got cnt=%0d, required no result", c16);
            end else begin
                e = sb16.pop_front();
                if (c16 != e.cnt || z16 != e.zero || n16 != e.norm) begin
                    errors++;
                    $display("FAIL result16: got cnt=%0d z=%0b norm=%h, required cnt=%0d z=%0b norm=%h",
                             c16, z16, n16, e.cnt, e.zero, e.norm);
                end
            end
        end
    end

    task automatic send(input logic [63:0] d, input logic [3:0] t,
                        input logic [6:0] c, input logic z, input logic [63:0] n);
        exp_t e;
        int   w;
        w = 0;
        @(negedge clk);
        valid_i = 1'b1;
        data_i  = d;
        tag_i   = t;
        while (!ready_o && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!ready_o) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got ready_o=0 for 200 cycles, required acceptance of tag %h", t);
            valid_i = 1'b0;
        end else begin
            e.cnt = c; e.zero = z; e.norm = n; e.tag = t;
            sb.push_back(e);
            n_acc++;
            @(posedge clk);
            #1;
            valid_i = 1'b0;
            data_i  = 64'h0;
        end
    endtask

    task automatic send16(input logic [15:0] d, input logic [4:0] c, input logic z, input logic [15:0] n);
        exp16_t e;
        @(negedge clk);
        v16 = 1'b1;
        d16 = d;
        checks++;
        if (!r16_o) begin
            errors++;
            $display("FAIL accept16: got ready_o=0, required 1");
        end else begin
            e.cnt = c; e.zero = z; e.norm = n;
            sb16.push_back(e);
        end
        @(posedge clk);
        #1;
        v16 = 1'b0;
    endtask

    task automatic check_idle(input string name);
        checks++;
        if (valid_o || count_o != 7'd0 || zero_o || norm_o != 64'h0 || tag_o != 4'h0 || !ready_o) begin
            errors++;
            $display("FAIL %s: got v=%0b cnt=%0d z=%0b norm=%h tag=%h rdy=%0b, required v=0 cnt=0 z=0 norm=0 tag=0 rdy=1",
                     name, valid_o, count_o, zero_o, norm_o, tag_o, ready_o);
        end
    endtask

    task automatic drain(input string name, input int budget);
        int w;
        w = 0;
        while (sb.size() != 0 && w < budget) begin
            @(negedge clk);
            w++;
        end
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s: got %0d results outstanding after %0d cycles, required 0", name, sb.size(), budget);
        end
    endtask

    function automatic void ref64(input logic [63:0] d, output logic [6:0] c,
                                  output logic z, output logic [63:0] n);
        c = 7'd64;
        for (int i = 0; i < 64; i++) begin
            if (d[i]) c = 7'(63 - i);
        end
        z = (d == 64'h0);
        n = z ? 64'h0 : (d << c);
    endfunction

    initial begin
        logic [63:0] rd;
        logic [6:0]  rc;
        logic        rz;
        logic [63:0] rn;
        int          msb;

        repeat (3) @(posedge clk);
        #1;
        rst_i = 1'b0;
        @(negedge clk);
        check_idle("reset_state");

        // Latency: S1 after one edge, S2/valid_o after the second.
        send(64'h0000_0000_0000_0001, 4'h0, 7'd63, 1'b0, 64'h8000_0000_0000_0000);
        @(negedge clk);
        checks++;
        if (valid_o) begin
            errors++;
            $display("FAIL latency_early: got valid_o=1 one cycle after accept, required 0");
        end
        @(negedge clk);
        checks++;
        if (!valid_o) begin
            errors++;
            $display("FAIL latency: got valid_o=0 two cycles after accept, required 1");
        end

        send(64'h0000_0000_0000_0000, 4'h1, 7'd64, 1'b1, 64'h0);
        send(64'h8000_0000_0000_0000, 4'h2, 7'd0,  1'b0, 64'h8000_0000_0000_0000);
        send(64'h0000_00F0_0000_0000, 4'hA, 7'd24, 1'b0, 64'hF000_0000_0000_0000);
        send(64'h0000_0000_0000_0300, 4'h5, 7'd54, 1'b0, 64'hC000_0000_0000_0000);
        drain("drain_directed", 10);

        // Back-pressure: only two operands fit, outputs must hold.
        rdy_fixed = 1'b0;
        repeat (2) @(negedge clk);
        n_acc = 0;
        fork
            begin
                send(64'h0100_0000_0000_0000, 4'h1, 7'd7,  1'b0, 64'h8000_0000_0000_0000);
                send(64'h0000_0001_0000_0000, 4'h2, 7'd31, 1'b0, 64'h8000_0000_0000_0000);
                send(64'h0000_0000_0000_0300, 4'h3, 7'd54, 1'b0, 64'hC000_0000_0000_0000);
                send(64'h7FFF_FFFF_FFFF_FFFF, 4'h4, 7'd1,  1'b0, 64'hFFFF_FFFF_FFFF_FFFE);
            end
        join_none
        repeat (6) @(negedge clk);
        checks++;
        if (ready_o || n_acc != 2) begin
            errors++;
            $display("FAIL backpressure: got ready_o=%0b accepted=%0d, required ready_o=0 accepted=2", ready_o, n_acc);
        end
        rdy_fixed = 1'b1;
        @(posedge clk);
        #2;
        drain("throughput", 4);
        wait fork;
        drain("drain_bp", 10);

        // Reset with both stages full.
        rdy_fixed = 1'b0;
        repeat (2) @(negedge clk);
        send(64'h0000_0000_0000_00FF, 4'h6, 7'd56, 1'b0, 64'hFF00_0000_0000_0000);
        send(64'h0000_0000_0000_0F00, 4'h7, 7'd52, 1'b0, 64'hF000_0000_0000_0000);
        @(negedge clk);
        checks++;
        if (ready_o || !valid_o) begin
            errors++;
            $display("FAIL full_before_reset: got ready_o=%0b valid_o=%0b, required 0 and 1", ready_o, valid_o);
        end
        @(posedge clk);
        #1;
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        sb.delete();
        rdy_fixed = 1'b1;
        @(negedge clk);
        check_idle("reset_flush");
        send(64'h0000_0000_0000_0001, 4'h9, 7'd63, 1'b0, 64'h8000_0000_0000_0000);
        drain("drain_after_reset", 10);

        // Random operands against a bit-scan reference, random downstream ready.
        rdy_rand = 1'b1;
        for (int i = 0; i < 40; i++) begin
            msb = $urandom_range(0, 64);
            if (msb == 64) begin
                rd = 64'h0;
            end else begin
                rd = {$urandom, $urandom};
                rd = rd >> (63 - msb);
                rd[msb] = 1'b1;
            end
            ref64(rd, rc, rz, rn);
            send(rd, 4'(i), rc, rz, rn);
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end
        rdy_rand  = 1'b0;
        rdy_fixed = 1'b1;
        drain("drain_random", 200);

        // XLEN=16 instance.
        send16(16'h0001, 5'd15, 1'b0, 16'h8000);
        send16(16'h0000, 5'd16, 1'b1, 16'h0000);
        send16(16'h00F0, 5'd8,  1'b0, 16'hF000);
        send16(16'h8000, 5'd0,  1'b0, 16'h8000);
        send16(16'h0123, 5'd7,  1'b0, 16'h9180);
        repeat (4) @(negedge clk);
        checks++;
        if (sb16.size() != 0) begin
            errors++;
            $display("FAIL drain16: got %0d results outstanding, required 0", sb16.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running at 200000, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
